kirby_info_gen: RTL and testbench

- Per-frame game-state producer that generates the packed Map_Info and Kirby_Info words read by the colour mapper.
- Samples the keyboard keycode once per video frame and steps Kirby's movement state machine, position, animation frame and map scroll.
- Registers both words so the pixel pipeline sees a stable value for the whole frame.

---
 rtl/kirby_info_pkg.sv | 52 +++++
 rtl/kirby_info_gen_frame_tick_sync.sv | 44 ++++
 rtl/kirby_info_gen.sv | 218 +++++++++++++++++++++
 tb/tb_kirby_info_gen.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/kirby_info_pkg.sv
// Shared types and constants for the Kirby game-state producer: movement states,
// keycodes, movement limits and the bit layout of the Map_Info / Kirby_Info words.
package kirby_info_pkg;

  typedef enum logic [1:0] {
    ST_STAND = 2'd0,
    ST_WALK  = 2'd1,
    ST_JUMP  = 2'd2,
    ST_FALL  = 2'd3
  } kirby_state_e;

  localparam logic [7:0] KEY_LEFT  = 8'h04;
  localparam logic [7:0] KEY_RIGHT = 8'h07;
  localparam logic [7:0] KEY_JUMP  = 8'h2C;

  localparam logic [7:0] X_START     = 8'd16;
  localparam logic [7:0] X_MAX       = 8'd248;
  localparam logic [7:0] GROUND_Y    = 8'd200;
  localparam logic [7:0] SCROLL_X    = 8'd120;
  localparam logic [7:0] MAP_X_MAX   = 8'd192;
  localparam logic [7:0] WALK_STEP   = 8'd2;
  localparam logic [7:0] JUMP_STEP   = 8'd4;
  localparam logic [7:0] FALL_STEP   = 8'd4;
  localparam logic [3:0] JUMP_FRAMES = 4'd8;
  localparam logic [2:0] ANIM_DIV    = 3'd4;

  localparam int MI_IDX_LSB  = 16;
  localparam int MI_IMGX_LSB = 8;
  localparam int MI_IMGY_LSB = 0;
  localparam int KI_X_LSB    = 24;
  localparam int KI_Y_LSB    = 16;
  localparam int KI_COL_LSB  = 8;
  localparam int KI_ROW_LSB  = 0;

  localparam logic [7:0] ROW_STAND = 8'd0;
  localparam logic [7:0] ROW_WALK  = 8'd1;
  localparam logic [7:0] ROW_JUMP  = 8'd2;
  localparam logic [7:0] ROW_FALL  = 8'd3;

  function automatic logic [7:0] state_row(input kirby_state_e s);
    logic [7:0] row;
    case (s)
      ST_STAND: row = ROW_STAND;
      ST_WALK:  row = ROW_WALK;
      ST_JUMP:  row = ROW_JUMP;
      ST_FALL:  row = ROW_FALL;
      default:  row = ROW_STAND;
    endcase
    return row;
  endfunction

endpackage

// File: rtl/kirby_info_gen_frame_tick_sync.sv
// Brings frame_clk into the Clk domain and emits a one-Clk tick per rising edge.
// A tick is only allowed once a genuine low level has been sampled after reset.
module frame_tick_sync (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_clk,
  output logic tick
);

  logic sync1_q, sync2_q, sync3_q;
  logic sync1_d, sync2_d, sync3_d;
  logic primed_q, primed_d;
  logic armed_q, armed_d;

  // Next-state of the synchroniser chain and the post-reset arming flags.
  always_comb begin
    sync1_d  = frame_clk;
    sync2_d  = sync1_q;
    sync3_d  = sync2_q;
    primed_d = 1'b1;
    // Without this, a frame_clk held high through reset would look like a fresh edge.
    armed_d  = armed_q | (primed_q & ~sync1_q);
  end

  // Synchroniser and arming registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      sync3_q  <= 1'b0;
      primed_q <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      sync3_q  <= sync3_d;
      primed_q <= primed_d;
      armed_q  <= armed_d;
    end
  end

  assign tick = sync2_q & ~sync3_q & armed_q;

endmodule

// File: rtl/kirby_info_gen.sv
// Per-frame Kirby movement, animation and map-scroll state, packed into Map_Info/Kirby_Info.
// Define KIRBY_DOUBLE_JUMP_EN to allow one extra jump while airborne.
module kirby_info_gen
  import kirby_info_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic [7:0]  keycode,
  output logic [31:0] Map_Info,
  output logic [31:0] Kirby_Info,
  output logic        info_valid
);

  logic         tick_s;
  logic         key_left_s, key_right_s, key_jump_s, air_jump_s;
  logic [8:0]   x_step_s, map_step_s, y_fall_s;
  logic [7:0]   y_rise_s;
  kirby_state_e state_q, state_d;
  logic [7:0]   x_q, x_d, y_q, y_d, map_x_q, map_x_d;
  logic [1:0]   idx_q, idx_d, col_q, col_d;
  logic [2:0]   div_q, div_d;
  logic [3:0]   jcnt_q, jcnt_d;
  logic         info_valid_q, info_valid_d;
  logic [31:0]  map_info_s, kirby_info_s;

  frame_tick_sync u_sync (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .tick      (tick_s)
  );

`ifdef KIRBY_DOUBLE_JUMP_EN
  logic dj_used_q, dj_used_d;
  assign air_jump_s = key_jump_s & ~dj_used_q;
`else
  assign air_jump_s = 1'b0;
`endif

  // Key decode and the saturating-arithmetic helpers used by the update logic.
  always_comb begin
    key_left_s  = (keycode == KEY_LEFT);
    key_right_s = (keycode == KEY_RIGHT);
    key_jump_s  = (keycode == KEY_JUMP);
    x_step_s    = {1'b0, x_q} + {1'b0, WALK_STEP};
    map_step_s  = {1'b0, map_x_q} + {1'b0, WALK_STEP};
    y_fall_s    = {1'b0, y_q} + {1'b0, FALL_STEP};
    if (y_q < JUMP_STEP) begin
      y_rise_s = 8'd0;
    end else begin
      y_rise_s = y_q - JUMP_STEP;
    end
  end

  // Per-tick game-state update: movement, state machine, animation and area change.
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    map_x_d      = map_x_q;
    idx_d        = idx_q;
    col_d        = col_q;
    div_d        = div_q;
    jcnt_d       = jcnt_q;
    info_valid_d = tick_s;
`ifdef KIRBY_DOUBLE_JUMP_EN
    dj_used_d    = dj_used_q;
`endif
    if (tick_s) begin
      if (key_left_s) begin
        if (x_q < WALK_STEP) begin
          x_d = 8'd0;
        end else begin
          x_d = x_q - WALK_STEP;
        end
      end else if (key_right_s) begin
        if (x_q < SCROLL_X) begin
          x_d = (x_step_s > {1'b0, SCROLL_X}) ? SCROLL_X : x_step_s[7:0];
        end else if (map_x_q < MAP_X_MAX) begin
          map_x_d = (map_step_s > {1'b0, MAP_X_MAX}) ? MAP_X_MAX : map_step_s[7:0];
        end else begin
          x_d = (x_step_s > {1'b0, X_MAX}) ? X_MAX : x_step_s[7:0];
        end
      end else begin
        x_d = x_q;
      end

      case (state_q)
        ST_STAND, ST_WALK: begin
          if (key_jump_s) begin
            state_d = ST_JUMP;
            jcnt_d  = 4'd0;
          end else if (key_left_s || key_right_s) begin
            state_d = ST_WALK;
          end else begin
            state_d = ST_STAND;
          end
        end
        ST_JUMP: begin
          y_d = y_rise_s;
          if (air_jump_s) begin
            jcnt_d = 4'd0;
`ifdef KIRBY_DOUBLE_JUMP_EN
            dj_used_d = 1'b1;
`endif
          end else if (jcnt_q == JUMP_FRAMES - 4'd1) begin
            state_d = ST_FALL;
            jcnt_d  = 4'd0;
          end else begin
            jcnt_d = jcnt_q + 4'd1;
          end
        end
        ST_FALL: begin
          if (air_jump_s) begin
            state_d = ST_JUMP;
            y_d     = y_rise_s;
            jcnt_d  = 4'd0;
`ifdef KIRBY_DOUBLE_JUMP_EN
            dj_used_d = 1'b1;
`endif
          end else if (y_fall_s >= {1'b0, GROUND_Y}) begin
            state_d = ST_STAND;
            y_d     = GROUND_Y;
`ifdef KIRBY_DOUBLE_JUMP_EN
            dj_used_d = 1'b0;
`endif
          end else begin
            y_d = y_fall_s[7:0];
          end
        end
        default: begin
          state_d = ST_STAND;
        end
      endcase

      if ((state_q == ST_WALK) && (state_d == ST_WALK)) begin
        if (div_q == ANIM_DIV - 3'd1) begin
          div_d = 3'd0;
          col_d = col_q + 2'd1;
        end else begin
          div_d = div_q + 3'd1;
        end
      end else begin
        div_d = 3'd0;
        col_d = 2'd0;
      end

      // Area change overrides everything computed above in the same tick.
      if (key_right_s && (x_d >= X_MAX)) begin
        idx_d   = idx_q + 2'd1;
        map_x_d = 8'd0;
        x_d     = X_START;
        y_d     = GROUND_Y;
        state_d = ST_STAND;
        col_d   = 2'd0;
        div_d   = 3'd0;
        jcnt_d  = 4'd0;
`ifdef KIRBY_DOUBLE_JUMP_EN
        dj_used_d = 1'b0;
`endif
      end else begin
        idx_d = idx_q;
      end
    end else begin
      state_d = state_q;
    end
  end

  // Game-state registers; both output words are built only from these.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= ST_STAND;
      x_q          <= X_START;
      y_q          <= GROUND_Y;
      map_x_q      <= 8'd0;
      idx_q        <= 2'd0;
      col_q        <= 2'd0;
      div_q        <= 3'd0;
      jcnt_q       <= 4'd0;
      info_valid_q <= 1'b0;
`ifdef KIRBY_DOUBLE_JUMP_EN
      dj_used_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      map_x_q      <= map_x_d;
      idx_q        <= idx_d;
      col_q        <= col_d;
      div_q        <= div_d;
      jcnt_q       <= jcnt_d;
      info_valid_q <= info_valid_d;
`ifdef KIRBY_DOUBLE_JUMP_EN
      dj_used_q    <= dj_used_d;
`endif
    end
  end

  // Pack the registered state into the two words read by the colour mapper.
  always_comb begin
    map_info_s                         = 32'd0;
    map_info_s[MI_IDX_LSB +: 2]        = idx_q;
    map_info_s[MI_IMGX_LSB +: 8]       = map_x_q;
    map_info_s[MI_IMGY_LSB +: 8]       = 8'd0;
    kirby_info_s                       = 32'd0;
    kirby_info_s[KI_X_LSB +: 8]        = x_q;
    kirby_info_s[KI_Y_LSB +: 8]        = y_q;
    kirby_info_s[KI_COL_LSB +: 8]      = {6'd0, col_q};
    kirby_info_s[KI_ROW_LSB +: 8]      = state_row(state_q);
  end

  assign Map_Info   = map_info_s;
  assign Kirby_Info = kirby_info_s;
  assign info_valid = info_valid_q;

endmodule

// File: tb/tb_kirby_info_gen.sv
// Directed self-checking bench for kirby_info_gen: reset, walking/scrolling,
// area changes, jumping, left clamp and reset/held-high frame_clk behaviour.
module tb_kirby_info_gen;

  logic        Clk;
  logic        Reset;
  logic        frame_clk;
  logic [7:0]  keycode;
  logic [31:0] Map_Info;
  logic [31:0] Kirby_Info;
  logic        info_valid;

  int checks = 0;
  int errors = 0;
  logic iv_pulse, iv_after, iv_seen;

  kirby_info_gen dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_clk  (frame_clk),
    .keycode    (keycode),
    .Map_Info   (Map_Info),
    .Kirby_Info (Kirby_Info),
    .info_valid (info_valid)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full frame: frame_clk high 4 Clk cycles, then low 4 cycles.
  task automatic do_tick(input logic [7:0] kc);
    @(negedge Clk);
    keycode   = kc;
    frame_clk = 1'b1;
    repeat (3) @(negedge Clk);
    iv_pulse = info_valid;
    @(negedge Clk);
    iv_after  = info_valid;
    frame_clk = 1'b0;
    repeat (4) @(negedge Clk);
  endtask

  function automatic logic [31:0] kword(input int x, input int y, input int col, input int row);
    logic [7:0] xb, yb, cb, rb;
    xb = 8'(x); yb = 8'(y); cb = 8'(col); rb = 8'(row);
    return {xb, yb, cb, rb};
  endfunction

  function automatic logic [31:0] mword(input int idx, input int mx);
    logic [7:0] ib, mb;
    ib = 8'(idx); mb = 8'(mx);
    return {8'd0, ib, mb, 8'd0};
  endfunction

  initial begin
    int ex_x, ex_map, ex_y, ex_row;
    Reset = 1'b1; frame_clk = 1'b0; keycode = 8'h00;
    iv_pulse = 1'b0; iv_after = 1'b0; iv_seen = 1'b0;
    repeat (3) @(negedge Clk);
    check("reset_kirby", Kirby_Info, 32'h10C80000);
    check("reset_map", Map_Info, 32'h00000000);
    check("reset_valid", {31'd0, info_valid}, 32'd0);
    Reset = 1'b0;
    repeat (6) @(negedge Clk);
    check("idle_kirby", Kirby_Info, 32'h10C80000);
    check("idle_valid", {31'd0, info_valid}, 32'd0);

    // Four full areas walking right; the fourth starts from idx 3 and wraps to 0.
    for (int a = 0; a < 4; a++) begin
      for (int n = 1; n <= 212; n++) begin
        do_tick(8'h07);
        if (n < 212) begin
          if (n <= 52) begin
            ex_x = 16 + 2 * n; ex_map = 0;
          end else if (n <= 148) begin
            ex_x = 120; ex_map = 2 * (n - 52);
          end else begin
            ex_x = 120 + 2 * (n - 148); ex_map = 192;
          end
          check("walk_kirby", Kirby_Info, kword(ex_x, 200, ((n - 1) / 4) % 4, 1));
          check("walk_map", Map_Info, mword(a, ex_map));
        end else begin
          check("area_kirby", Kirby_Info, 32'h10C80000);
          check("area_map", Map_Info, mword((a + 1) % 4, 0));
        end
        if (n == 1) begin
          check("valid_pulse", {31'd0, iv_pulse}, 32'd1);
          check("valid_one_cycle", {31'd0, iv_after}, 32'd0);
        end
      end
    end

    // Scroll the map to 16, then walk left into the X=0 clamp.
    for (int n = 1; n <= 60; n++) do_tick(8'h07);
    check("pre_left_kirby", Kirby_Info, kword(120, 200, 2, 1));
    check("pre_left_map", Map_Info, mword(0, 16));
    for (int k = 1; k <= 62; k++) begin
      do_tick(8'h04);
      ex_x = (k <= 60) ? 120 - 2 * k : 0;
      check("left_x", {24'd0, Kirby_Info[31:24]}, 32'(ex_x));
      check("left_map", Map_Info, mword(0, 16));
    end
    do_tick(8'h00);
    check("stop_kirby", Kirby_Info, kword(0, 200, 0, 0));

    // Single jump: eight rising ticks, eight falling ticks.
    do_tick(8'h2C);
    check("jump_start", Kirby_Info, kword(0, 200, 0, 2));
    for (int k = 1; k <= 8; k++) begin
      do_tick(8'h00);
      check("jump_rise", Kirby_Info, kword(0, 200 - 4 * k, 0, (k < 8) ? 2 : 3));
    end
    for (int k = 1; k <= 8; k++) begin
      do_tick(8'h00);
      check("jump_fall", Kirby_Info, kword(0, 168 + 4 * k, 0, (k < 8) ? 3 : 0));
    end

    // Jump key pressed repeatedly while airborne.
    do_tick(8'h2C);
    for (int k = 1; k <= 5; k++) do_tick(8'h00);
    check("air_at_180", Kirby_Info, kword(0, 180, 0, 2));
    do_tick(8'h2C);
    check("air_press1", Kirby_Info, kword(0, 176, 0, 2));
    do_tick(8'h2C);
    check("air_press2", Kirby_Info, kword(0, 172, 0, 2));
    do_tick(8'h2C);
`ifdef KIRBY_DOUBLE_JUMP_EN
    ex_row = 2;
`else
    ex_row = 3;
`endif
    check("air_press3", Kirby_Info, kword(0, 168, 0, ex_row));
    for (int k = 1; k <= 24; k++) do_tick(8'h00);
    check("air_landed", Kirby_Info, kword(0, 200, 0, 0));

    // Reset after sync1 has captured a rising frame_clk.
    @(negedge Clk);
    frame_clk = 1'b1;
    @(negedge Clk);
    Reset = 1'b1;
    #1;
    check("midrst_kirby", Kirby_Info, 32'h10C80000);
    check("midrst_map", Map_Info, 32'h00000000);
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge Clk);
      iv_seen = iv_seen | info_valid;
    end
    check("midrst_no_valid", {31'd0, iv_seen}, 32'd0);
    check("midrst_hold", Kirby_Info, 32'h10C80000);
    frame_clk = 1'b0;
    repeat (4) @(negedge Clk);
    do_tick(8'h00);
    check("post_rst_tick", {31'd0, iv_pulse}, 32'd1);
    check("post_rst_kirby", Kirby_Info, 32'h10C80000);
    do_tick(8'h07);
    check("post_rst_walk", Kirby_Info, kword(18, 200, 0, 1));

    // A long high frame_clk gives exactly one step.
    @(negedge Clk);
    keycode = 8'h07;
    frame_clk = 1'b1;
    repeat (30) @(negedge Clk);
    ex_y = 200;
    check("held_high", Kirby_Info, kword(20, ex_y, 0, 1));
    frame_clk = 1'b0;
    repeat (4) @(negedge Clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
